// File: rtl/layer_sequencer.sv
// layer_sequencer: walks one dense layer of the MAC datapath.
// For each output neuron j it clears the accumulator, issues N_IN
// input/weight index pairs, waits MEM_LAT cycles for the last operand
// to reach the MAC, then strobes the accumulator into the output buffer.
// A high 'hold' freezes every piece of state and masks all strobes, so the
// datapath registers must freeze on the same 'hold' for results to stay aligned.
module layer_sequencer #(
  parameter int N_IN    = 16,
  parameter int N_OUT   = 8,
  parameter int MEM_LAT = 1,
  parameter int IDX_W   = 8,
  parameter int WA_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] in_idx,
  output logic [WA_W-1:0]  w_idx,
  output logic [IDX_W-1:0] out_idx,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             out_we
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(N_OUT - 1);
  localparam logic [2:0]       LAT_LAST = 3'(MEM_LAT - 1);

  state_t state;
  state_t next_state;

  // Bit k high means an operand issued k+1 cycles ago is in flight;
  // the top bit marks the operand arriving at the MAC this cycle.
  logic [MEM_LAT-1:0] issue_line;
  logic               issue_valid;
  logic [2:0]         drain_cnt;

  assign issue_valid = (state == ISSUE);

  // State register; reset returns straight to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode; while held, state stays put and strobes are masked.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    acc_clr    = 1'b0;
    out_we     = 1'b0;
    acc_en     = issue_line[MEM_LAT-1] & ~hold;
    if (!hold) begin
      case (state)
        IDLE: begin
          if (start) begin
            next_state = CLEAR;
          end
        end
        CLEAR: begin
          acc_clr    = 1'b1;
          next_state = ISSUE;
        end
        ISSUE: begin
          if (in_idx == IN_LAST) begin
            next_state = DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == LAT_LAST) begin
            next_state = WRITE;
          end
        end
        WRITE: begin
          out_we     = 1'b1;
          next_state = (out_idx == OUT_LAST) ? DONE : CLEAR;
        end
        DONE: begin
          done       = 1'b1;
          next_state = IDLE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Index counters, drain timer and operand delay line.
  // Indices are loaded on the edge that enters each ISSUE cycle, so they hold
  // their last issued values everywhere else; w_idx is a running +1 adder that
  // restarts at zero only for the first neuron of a layer.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx     <= '0;
      w_idx      <= '0;
      out_idx    <= '0;
      drain_cnt  <= '0;
      issue_line <= '0;
    end else if (!hold) begin
      issue_line <= (issue_line << 1) | MEM_LAT'(issue_valid);
      case (state)
        IDLE: begin
          if (start) begin
            out_idx <= '0;
          end
        end
        CLEAR: begin
          in_idx <= '0;
          w_idx  <= (out_idx == '0) ? '0 : w_idx + WA_W'(1);
        end
        ISSUE: begin
          if (in_idx != IN_LAST) begin
            in_idx <= in_idx + IDX_W'(1);
            w_idx  <= w_idx + WA_W'(1);
          end else begin
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
        end
        WRITE: begin
          if (out_idx != OUT_LAST) begin
            out_idx <= out_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
